reg_write_arbiter: RTL and testbench

Write-port controller for the 8x8 register file. Shares the file's single write port between two requesters, port 0 (ALU writeback) and port 1 (memory load), using a valid/ready handshake and round-robin priority. Also runs a clear sequence that writes 0 to r0..r7 one register per cycle. Its outputs drive the register file's IN, INADDRESS and WRITE directly; read ports are untouched.

---
 rtl/reg_write_arbiter_pkg.sv | 12 +
 rtl/reg_write_arbiter_if.sv | 17 +
 rtl/reg_write_arbiter_rr.sv | 30 +++
 rtl/reg_write_arbiter.sv | 100 ++++++++++
 tb/tb_reg_write_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the register-file write controller.
//   DATA_WIDTH : register data width
//   ADDR_WIDTH : register address width
//   NUM_REGS   : registers swept by a clear
//   state_t    : controller FSM states
package reg_ctrl_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef enum logic {S_RUN, S_CLEAR} state_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Two-requester write handshake bundle (port 0 ALU writeback, port 1 load).
//   VALIDn/ADDRn/DATAn : request from requester n
//   READYn             : grant back to requester n (combinational)
//   master : requester side, slave : arbiter side
interface reg_write_arbiter_if;
  import reg_ctrl_pkg::*;

  logic                  VALID0, VALID1;
  logic [ADDR_WIDTH-1:0] ADDR0, ADDR1;
  logic [DATA_WIDTH-1:0] DATA0, DATA1;
  logic                  READY0, READY1;

  modport master (output VALID0, ADDR0, DATA0, VALID1, ADDR1, DATA1,
                  input  READY0, READY1);
  modport slave  (input  VALID0, ADDR0, DATA0, VALID1, ADDR1, DATA1,
                  output READY0, READY1);
endinterface

// File: rtl/reg_write_arbiter_rr.sv
// Two-way round-robin arbiter.
//   CLK, RESET : clock, synchronous active-high reset
//   req        : request vector, bit n = requester n
//   en         : grants are allowed this cycle
//   gnt        : one-hot grant (combinational)
// The priority pointer names the port that wins a tie; after any grant it
// moves to the other port, so a continuously contended port alternates.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !prio)) gnt[0] = 1'b1;
      else if (req[1])                  gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)       prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Write-port controller for the 8x8 register file.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : two-requester valid/ready write handshake
//   CLEAR      : request a zero-fill of every register
//   BUSY       : clear sequence in progress
//   CLEAR_DONE : one-cycle pulse after the last clear write
//   WRITE/INADDRESS/IN : registered write port into the register file
module reg_write_arbiter
  import reg_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  reg_write_arbiter_if.slave    bus,
  input  logic                  CLEAR,
  output logic                  BUSY,
  output logic                  CLEAR_DONE,
  output logic                  WRITE,
  output logic [ADDR_WIDTH-1:0] INADDRESS,
  output logic [DATA_WIDTH-1:0] IN
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  write_nxt, done_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] in_nxt;
  logic [1:0]            gnt;
  logic                  gnt_en;

  // CLEAR beats any request in the same cycle; nothing is granted in reset.
  assign gnt_en = (state == S_RUN) && !CLEAR && !RESET;

  rr_arbiter2 u_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .req   ({bus.VALID1, bus.VALID0}),
    .en    (gnt_en),
    .gnt   (gnt)
  );

  assign bus.READY0 = gnt[0];
  assign bus.READY1 = gnt[1];
  assign BUSY       = (state == S_CLEAR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    write_nxt = 1'b0;
    addr_nxt  = INADDRESS;
    in_nxt    = IN;
    done_nxt  = 1'b0;
    case (state)
      S_RUN: begin
        if (CLEAR) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end else if (gnt[0]) begin
          write_nxt = 1'b1;
          addr_nxt  = bus.ADDR0;
          in_nxt    = bus.DATA0;
        end else if (gnt[1]) begin
          write_nxt = 1'b1;
          addr_nxt  = bus.ADDR1;
          in_nxt    = bus.DATA1;
        end
      end
      S_CLEAR: begin
        // CLEAR is not looked at here: a re-request during a sweep is dropped.
        write_nxt = 1'b1;
        addr_nxt  = cnt;
        in_nxt    = '0;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_RUN;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_RUN;
      cnt        <= '0;
      WRITE      <= 1'b0;
      INADDRESS  <= '0;
      IN         <= '0;
      CLEAR_DONE <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      WRITE      <= write_nxt;
      INADDRESS  <= addr_nxt;
      IN         <= in_nxt;
      CLEAR_DONE <= done_nxt;
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based model of the write port and register file.
module tb_reg_write_arbiter;
  import reg_ctrl_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                  rst, clr;
  logic                  v0, v1;
  logic [ADDR_WIDTH-1:0] a0, a1;
  logic [DATA_WIDTH-1:0] d0, d1;
  logic                  BUSY, CLEAR_DONE, WRITE;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic [DATA_WIDTH-1:0] IN;

  reg_write_arbiter_if bus ();
  assign bus.VALID0 = v0;
  assign bus.ADDR0  = a0;
  assign bus.DATA0  = d0;
  assign bus.VALID1 = v1;
  assign bus.ADDR1  = a1;
  assign bus.DATA1  = d1;

  reg_write_arbiter dut (
    .CLK        (CLK),
    .RESET      (rst),
    .bus        (bus.slave),
    .CLEAR      (clr),
    .BUSY       (BUSY),
    .CLEAR_DONE (CLEAR_DONE),
    .WRITE      (WRITE),
    .INADDRESS  (INADDRESS),
    .IN         (IN)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: pending clear writes as a queue of addresses, last-winner pointer
  logic [ADDR_WIDTH-1:0] clr_q[$];
  int                    m_prio;
  logic                  e_w, e_done;
  logic [ADDR_WIDTH-1:0] e_a;
  logic [DATA_WIDTH-1:0] e_d;
  logic [DATA_WIDTH-1:0] rf_m [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf   [NUM_REGS];

  int   last_g;
  logic rdy0_s, rdy1_s, busy_s;
  logic                  cap_w;
  logic [ADDR_WIDTH-1:0] cap_a;
  logic [DATA_WIDTH-1:0] cap_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst || clr || clr_q.size() > 0) return -1;
    if (v0 && v1) return m_prio;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (e_w) rf_m[e_a] = e_d;
    if (rst) begin
      clr_q.delete();
      m_prio = 0; e_w = 0; e_a = '0; e_d = '0; e_done = 0;
    end else begin
      e_w = 0; e_done = 0;
      if (clr_q.size() > 0) begin
        e_a = clr_q.pop_front(); e_d = '0; e_w = 1;
        e_done = (clr_q.size() == 0);
      end else if (clr) begin
        for (int i = 0; i < NUM_REGS; i++) clr_q.push_back(ADDR_WIDTH'(i));
      end else if (g >= 0) begin
        e_w = 1;
        e_a = (g == 1) ? a1 : a0;
        e_d = (g == 1) ? d1 : d0;
        m_prio = 1 - g;
      end
    end
  endtask

  // one clock: combinational checks before the edge, registered checks after
  task automatic cycle();
    int g;
    @(negedge CLK);
    g = model_grant();
    rdy0_s = bus.READY0; rdy1_s = bus.READY1; busy_s = BUSY;
    chk("ready0", 32'(bus.READY0), 32'(g == 0));
    chk("ready1", 32'(bus.READY1), 32'(g == 1));
    chk("busy",   32'(BUSY),       32'(clr_q.size() > 0));
    cap_w = WRITE; cap_a = INADDRESS; cap_d = IN;
    @(posedge CLK);
    if (cap_w === 1'b1) rf[cap_a] = cap_d;
    model_edge(g);
    #1;
    chk("write",      32'(WRITE),      32'(e_w));
    chk("inaddress",  32'(INADDRESS),  32'(e_a));
    chk("in",         32'(IN),         32'(e_d));
    chk("clear_done", 32'(CLEAR_DONE), 32'(e_done));
    last_g = g;
  endtask

  task automatic idle_in();
    rst = 0; clr = 0; v0 = 0; v1 = 0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; cycle(); rst = 0;
  endtask

  int n_wr, n_done;
  logic [ADDR_WIDTH-1:0] exp_a;

  initial begin
    idle_in(); rst = 1; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_prio = 0; e_w = 0; e_a = '0; e_d = '0; e_done = 0; last_g = -1;
    for (int i = 0; i < NUM_REGS; i++) begin rf[i] = 'x; rf_m[i] = 'x; end

    // reset state
    cycle();
    chk("rst_ready0", 32'(rdy0_s), 0);
    chk("rst_write",  32'(WRITE), 0);
    chk("rst_busy",   32'(BUSY), 0);
    rst = 0;

    // single write
    v0 = 1; a0 = 3'd3; d0 = 8'h5A;
    cycle();
    chk("t1_ready0", 32'(rdy0_s), 1);
    chk("t1_write",  32'(WRITE), 1);
    chk("t1_addr",   32'(INADDRESS), 3);
    chk("t1_data",   32'(IN), 8'h5A);
    v0 = 0;
    cycle();
    chk("t1_write_off", 32'(WRITE), 0);

    // both valid from reset: alternate 0,1,0,1
    do_reset();
    v0 = 1; a0 = 3'd1; d0 = 8'h11; v1 = 1; a1 = 3'd2; d1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_gnt0", 32'(rdy0_s), 32'(i % 2 == 0));
      exp_a = (i % 2 == 0) ? 3'd1 : 3'd2;
      chk("t2_addr", 32'(INADDRESS), 32'(exp_a));
    end

    // port 1 alone, then port 0 joins and wins first
    v0 = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_gnt1", 32'(rdy1_s), 1);
    end
    v0 = 1;
    cycle();
    chk("t3_join_gnt0", 32'(rdy0_s), 1);

    // clear with a simultaneous request
    v1 = 0; v0 = 1; a0 = 3'd4; d0 = 8'hC4; clr = 1;
    cycle();
    chk("t4_no_grant", 32'(rdy0_s), 0);
    clr = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cycle();
      chk("t4_busy",  32'(busy_s), 1);
      chk("t4_addr",  32'(INADDRESS), i);
      chk("t4_zero",  32'(IN), 0);
    end
    chk("t4_done", 32'(CLEAR_DONE), 1);
    cycle();
    chk("t4_gnt_in_done_cycle", 32'(rdy0_s), 1);
    v0 = 0;
    cycle();
    chk("t4_done_once", 32'(CLEAR_DONE), 0);

    // reset while the clear is at CNT=4
    v0 = 1; a0 = 3'd5; d0 = 8'h55; cycle();
    a0 = 3'd6; d0 = 8'h66; cycle();
    a0 = 3'd7; d0 = 8'h77; cycle();
    v0 = 0; clr = 1; cycle(); clr = 0;
    for (int i = 0; i < 4; i++) cycle();
    rst = 1; cycle(); rst = 0;
    chk("t5_write", 32'(WRITE), 0);
    chk("t5_busy",  32'(BUSY), 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (CLEAR_DONE) n_done++; end
    chk("t5_no_done", n_done, 0);
    chk("t5_r5", 32'(rf[5]), 8'h55);
    chk("t5_r6", 32'(rf[6]), 8'h66);
    chk("t5_r7", 32'(rf[7]), 8'h77);

    // CLEAR re-asserted at CNT=2 is ignored
    clr = 1; cycle(); clr = 0;
    n_wr = 0; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      clr = (i == 2);
      cycle();
      if (WRITE && IN == 0) n_wr++;
      if (CLEAR_DONE) n_done++;
    end
    clr = 0;
    chk("t6_writes", n_wr, 8);
    chk("t6_done",   n_done, 1);

    // random traffic; requesters hold their request until granted
    for (int n = 0; n < 400; n++) begin
      if (!v0 || last_g == 0) begin
        v0 = 1'($urandom_range(0, 1)); a0 = ADDR_WIDTH'($urandom); d0 = DATA_WIDTH'($urandom);
      end
      if (!v1 || last_g == 1) begin
        v1 = 1'($urandom_range(0, 1)); a1 = ADDR_WIDTH'($urandom); d1 = DATA_WIDTH'($urandom);
      end
      clr = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_in();
    cycle();
    cycle();
    for (int i = 0; i < NUM_REGS; i++) chk("rf_final", 32'(rf[i]), 32'(rf_m[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
